// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction buffer.
// master = the fetch/decode environment, slave = the buffer itself.
interface if_id_queue_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   // Push handshake: a push happens on a cycle where if_valid && if_ready.
   // Pop handshake: a pop happens on a cycle where id_valid && !id_stall.
   // Neither handshake completes on a flush cycle.
   logic              if_valid;
   logic [ADDR_W-1:0] if_pc;
   logic [INST_W-1:0] if_inst;
   logic              if_ready;
   logic              id_stall;
   logic              id_valid;
   logic [ADDR_W-1:0] id_pc;
   logic [INST_W-1:0] id_inst;

   modport master (
      output if_valid, if_pc, if_inst, id_stall,
      input  if_ready, id_valid, id_pc, id_inst
   );

   modport slave (
      input  if_valid, if_pc, if_inst, id_stall,
      output if_ready, id_valid, id_pc, id_inst
   );
endinterface

// File: rtl/if_id_queue.sv
// Circular instruction buffer between fetch and decode; presents a zero
// bubble when empty and counts instructions handed to decode.
module if_id_queue #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   if_id_queue_if.slave     bus,
   output logic [CNT_W-1:0] count,
   output logic [31:0]      issued_cnt
);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic              push;
   logic              pop;

   // if_ready looks only at count, so a full buffer refuses a push even
   // when the head is leaving in the same cycle.
   assign bus.if_ready = (count != CNT_W'(DEPTH));
   assign bus.id_valid = (count != '0);
   assign bus.id_pc    = bus.id_valid ? pc_mem[rd_ptr]   : '0;
   assign bus.id_inst  = bus.id_valid ? inst_mem[rd_ptr] : '0;

   assign push = bus.if_valid && bus.if_ready && !flush;
   assign pop  = bus.id_valid && !bus.id_stall && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         issued_cnt <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr     <= rd_ptr + PTR_W'(1);
            issued_cnt <= issued_cnt + 32'd1;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is never cleared; stale entries are masked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= bus.if_pc;
         inst_mem[wr_ptr] <= bus.if_inst;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a per-cycle vector table plus hand
// sequences for streaming, full buffer and mid-stream reset.
module tb_if_id_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [2:0]  count;
   logic [31:0] issued_cnt;

   if_id_queue_if #(.ADDR_W(32), .INST_W(32)) bus ();

   if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .bus        (bus.slave),
      .count      (count),
      .issued_cnt (issued_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        fl;
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        st;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_cnt;
      logic        e_rdy;
      logic [31:0] e_iss;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(logic fl, logic v, logic [31:0] pc, logic [31:0] inst,
                               logic st, logic ev, logic [31:0] epc, logic [31:0] einst,
                               logic [31:0] ecnt, logic erdy, logic [31:0] eiss);
      vec_t r;
      r.fl = fl; r.v = v; r.pc = pc; r.inst = inst; r.st = st;
      r.e_valid = ev; r.e_pc = epc; r.e_inst = einst;
      r.e_cnt = ecnt; r.e_rdy = erdy; r.e_iss = eiss;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic st);
      flush        = fl;
      bus.if_valid = v;
      bus.if_pc    = pc;
      bus.if_inst  = inst;
      bus.id_stall = st;
   endtask

   initial begin
      // Outputs during each cycle, before that cycle's edge.
      vecs[0]  = mk(0, 1, 32'h100, 32'h00500093, 1, 0, 0, 0, 0, 1, 0);
      vecs[1]  = mk(0, 0, 0, 0, 1, 1, 32'h100, 32'h00500093, 1, 1, 0);
      vecs[2]  = mk(0, 0, 0, 0, 0, 1, 32'h100, 32'h00500093, 1, 1, 0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      vecs[4]  = mk(0, 1, 32'h00, 32'h1000, 1, 0, 0, 0, 0, 1, 1);
      vecs[5]  = mk(0, 1, 32'h04, 32'h1004, 1, 1, 32'h0, 32'h1000, 1, 1, 1);
      vecs[6]  = mk(0, 1, 32'h08, 32'h1008, 1, 1, 32'h0, 32'h1000, 2, 1, 1);
      vecs[7]  = mk(0, 1, 32'h0C, 32'h100C, 1, 1, 32'h0, 32'h1000, 3, 1, 1);
      vecs[8]  = mk(0, 1, 32'h10, 32'h1010, 1, 1, 32'h0, 32'h1000, 4, 0, 1);
      vecs[9]  = mk(0, 0, 0, 0, 1, 1, 32'h0, 32'h1000, 4, 0, 1);
      vecs[10] = mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h1000, 4, 0, 1);
      vecs[11] = mk(0, 0, 0, 0, 0, 1, 32'h4, 32'h1004, 3, 1, 2);
      vecs[12] = mk(0, 0, 0, 0, 0, 1, 32'h8, 32'h1008, 2, 1, 3);
      vecs[13] = mk(0, 0, 0, 0, 0, 1, 32'hC, 32'h100C, 1, 1, 4);
      vecs[14] = mk(0, 1, 32'h20, 32'h2020, 1, 0, 0, 0, 0, 1, 5);
      vecs[15] = mk(0, 1, 32'h24, 32'h2024, 1, 1, 32'h20, 32'h2020, 1, 1, 5);
      vecs[16] = mk(0, 1, 32'h28, 32'h2028, 1, 1, 32'h20, 32'h2020, 2, 1, 5);
      vecs[17] = mk(0, 1, 32'h2C, 32'h202C, 1, 1, 32'h20, 32'h2020, 3, 1, 5);
      vecs[18] = mk(0, 1, 32'h30, 32'h2030, 0, 1, 32'h20, 32'h2020, 4, 0, 5);
      vecs[19] = mk(0, 0, 0, 0, 1, 1, 32'h24, 32'h2024, 3, 1, 6);
      vecs[20] = mk(1, 1, 32'h40, 32'h2040, 0, 1, 32'h24, 32'h2024, 3, 1, 6);
      vecs[21] = mk(0, 1, 32'h44, 32'h2044, 1, 0, 0, 0, 0, 1, 6);
      vecs[22] = mk(0, 0, 0, 0, 0, 1, 32'h44, 32'h2044, 1, 1, 6);
      vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7);

      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].st);
         chk($sformatf("v%0d_id_valid", i), {31'b0, bus.id_valid}, {31'b0, vecs[i].e_valid});
         chk($sformatf("v%0d_id_pc", i), bus.id_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_id_inst", i), bus.id_inst, vecs[i].e_inst);
         chk($sformatf("v%0d_count", i), {29'b0, count}, vecs[i].e_cnt);
         chk($sformatf("v%0d_if_ready", i), {31'b0, bus.if_ready}, {31'b0, vecs[i].e_rdy});
         chk($sformatf("v%0d_issued", i), issued_cnt, vecs[i].e_iss);
         @(negedge clk);
      end

      // Streaming: a push and a pop every cycle, pointers wrap several times.
      for (int i = 0; i < 20; i++) begin
         drive(0, 1, 32'h200 + 32'(4 * i), 32'h3000 + 32'(i), 0);
         chk($sformatf("s%0d_count", i), {29'b0, count}, (i == 0) ? 32'd0 : 32'd1);
         chk($sformatf("s%0d_id_valid", i), {31'b0, bus.id_valid}, (i == 0) ? 32'd0 : 32'd1);
         if (bus.id_valid) begin
            if (exp_q.size() == 0) chk($sformatf("s%0d_unexpected_pop", i), 32'd1, 32'd0);
            else chk($sformatf("s%0d_id_pc", i), bus.id_pc, exp_q.pop_front());
         end
         if (bus.if_ready) exp_q.push_back(32'h200 + 32'(4 * i));
         @(negedge clk);
      end
      drive(0, 0, 0, 0, 1);
      chk("stream_issued", issued_cnt, 32'd26);
      chk("stream_count", {29'b0, count}, 32'd1);
      chk("stream_last_pc", bus.id_pc, 32'h24C);
      chk("stream_last_inst", bus.id_inst, 32'h3013);

      // Reset mid-stream with two entries buffered.
      drive(0, 1, 32'h250, 32'h3014, 1);
      @(negedge clk);
      chk("pre_rst_count", {29'b0, count}, 32'd2);
      rst = 1'b1;
      drive(0, 1, 32'h254, 32'h3015, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_issued", issued_cnt, 32'd0);
      chk("rst_if_ready", {31'b0, bus.if_ready}, 32'd1);
      chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
      chk("rst_id_pc", bus.id_pc, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised instruction buffer between the fetch stage and the decode stage, replacing the single-entry IF/ID register. It holds up to DEPTH fetched (pc, inst) pairs in FIFO order, absorbs decode stalls without stalling fetch until full, discards all contents on a control-flow flush and presents an all-zero bubble to decode when empty. A 32-bit counter of instructions delivered to decode supports performance monitoring.

## Interface
- ADDR_W, 32, width of pc fields
- INST_W, 32, width of instruction fields
- DEPTH, 4, number of entries; power of two, at least 2
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered entries (branch/jump redirect)
- if_valid  in  1  fetch presents a valid instruction this cycle
- if_pc  in  ADDR_W  pc of the fetched instruction
- if_inst  in  INST_W  fetched instruction word
- if_ready  out  1  buffer accepts a push this cycle
- id_stall  in  1  decode cannot consume this cycle
- id_valid  out  1  head entry is valid
- id_pc  out  ADDR_W  head pc; zero when empty
- id_inst  out  INST_W  head instruction; zero when empty
- count  out  clog2(DEPTH)+1  number of occupied entries
- issued_cnt  out  32  instructions delivered to decode since reset

## Operation
- Storage: DEPTH-entry circular array, read pointer rd_ptr, write pointer wr_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), occupancy count.
- if_ready = (count != DEPTH); purely combinational from count, independent of id_stall and flush. No bypass: full buffer refuses a push even when a pop happens that cycle.
- push = if_valid && if_ready && !flush: write (if_pc, if_inst) at wr_ptr, wr_ptr+1.
- pop = id_valid && !id_stall && !flush: rd_ptr+1, issued_cnt+1 (wraps 2^32-1 -> 0).
- id_valid = (count != 0). id_pc/id_inst = entry at rd_ptr when id_valid, else zero (bubble, same as the reset/stall bubble decode already treats as NOP).
- count next = count + push - pop; simultaneous push and pop leaves count unchanged, both pointers advance.
- Priority: rst > flush > push/pop. Flush: rd_ptr, wr_ptr, count to 0; incoming if_valid that cycle is dropped; head is not counted in issued_cnt; storage contents need not be cleared. issued_cnt is not cleared by flush.
- Entries at wrap-around behave identically to others; FIFO order is strictly preserved.

## Timing
- Reset values: if_ready 1, id_valid 0, id_pc 0, id_inst 0, count 0, issued_cnt 0; pointers 0.
- Latency: push in cycle N on empty buffer -> id_valid=1 with that entry in cycle N+1. No same-cycle fall-through.
- Throughput: one push and one pop per cycle sustained with id_stall low.
- id outputs are stable while id_stall is high and no flush occurs.
- Flush in cycle N -> id_valid=0, count=0, if_ready=1 in cycle N+1; a push in N+1 appears at id in N+2.
- Reset asserted mid-operation discards everything, same as flush, and also clears issued_cnt.

## Test plan
- Reset then idle: all outputs at reset values; push pc=0x100 inst=0x00500093 -> next cycle id_valid=1, id_pc=0x100, id_inst=0x00500093, count=1.
- Fill: id_stall=1, push 5 instructions pc 0x0..0x10 with DEPTH=4 -> if_ready=0 after 4th, 5th not accepted, count=4; release stall -> pcs 0x0,0x4,0x8,0xC delivered in order, issued_cnt=4.
- Streaming: if_valid=1, id_stall=0 for 20 cycles -> count stays 1, pointers wrap, 19 pops in order, issued_cnt=19, no gaps.
- Flush while count=3 with simultaneous if_valid -> next cycle count=0, id_valid=0, id_pc=0, issued_cnt unchanged.
- Full with simultaneous pop: count=4, id_stall=0, if_valid=1 -> pop occurs, push refused, count=3.
- Reset mid-stream with count=2, issued_cnt=7 -> next cycle count=0, issued_cnt=0, if_ready=1.
